cmd_queue: RTL and testbench

//   Command buffer directly downstream of gcode_analysis, in the 48 MHz domain.

---
 rtl/cmd_queue.sv | 126 ++++++++++++
 tb/tb_cmd_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_queue.sv
`default_nettype none
// ============================================================================
// cmd_queue : first-word-fall-through command buffer with fill level,
//             saturating overflow counter and host status word.
// Revision  : 1.0
// ============================================================================
module cmd_queue #(
  parameter int WID_8      = 8,
  parameter int WID_16     = 16,
  parameter int WID_32     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk_48m,
  input  logic                  rst_48m,
  input  logic                  clear,
  input  logic                  cmd_in_vld,
  input  logic [WID_8-1:0]      cmd_in_type,
  input  logic [WID_16-1:0]     cmd_in_data0,
  input  logic [WID_16-1:0]     cmd_in_data1,
  input  logic [WID_16-1:0]     cmd_in_data2,
  input  logic [WID_16-1:0]     cmd_in_data3,
  output logic                  q_vld,
  input  logic                  q_rdy,
  output logic [WID_8-1:0]      q_type,
  output logic [WID_16-1:0]     q_data0,
  output logic [WID_16-1:0]     q_data1,
  output logic [WID_16-1:0]     q_data2,
  output logic [WID_16-1:0]     q_data3,
  output logic [DEPTH_LOG2:0]   q_level,
  output logic                  q_full,
  output logic                  q_almost_full,
  output logic [WID_16-1:0]     ovf_cnt,
  output logic [WID_32-1:0]     status_word
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int ENTRY_W = WID_8 + 4 * WID_16;
  localparam int LVL_W   = DEPTH_LOG2 + 1;

  localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]      LVL_AF   = LVL_W'(DEPTH - AF_MARGIN);
  localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [WID_16-1:0]     OVF_ONE  = WID_16'(1);
  localparam logic [WID_16-1:0]     OVF_MAX  = '1;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [WID_16-1:0]     ovf_cnt_q, ovf_cnt_d;
  logic                  pop, push_ok, wr_en;
  logic [ENTRY_W-1:0]    head;

  assign q_vld         = (level_q != '0);
  assign q_full        = (level_q == LVL_FULL);
  assign q_almost_full = (level_q >= LVL_AF);
  assign q_level       = level_q;
  assign ovf_cnt       = ovf_cnt_q;

  assign head    = mem_q[rd_ptr_q];
  assign q_type  = head[ENTRY_W-1 -: WID_8];
  assign q_data0 = head[4*WID_16-1 -: WID_16];
  assign q_data1 = head[3*WID_16-1 -: WID_16];
  assign q_data2 = head[2*WID_16-1 -: WID_16];
  assign q_data3 = head[WID_16-1:0];

  always_comb begin
    status_word                      = '0;
    status_word[WID_32-1 -: WID_16]  = ovf_cnt_q;
    status_word[LVL_W+1]             = q_almost_full;
    status_word[LVL_W]               = q_full;
    status_word[LVL_W-1:0]           = level_q;
  end

  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  always_comb begin
    pop       = q_vld & q_rdy;
    push_ok   = cmd_in_vld & (~q_full | pop);
    wr_en     = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_cnt_d = ovf_cnt_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      ovf_cnt_d = '0;
    end else begin
      wr_en = push_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      if (cmd_in_vld && !push_ok && ovf_cnt_q != OVF_MAX)
        ovf_cnt_d = ovf_cnt_q + OVF_ONE;
    end
  end

  always_ff @(posedge clk_48m or posedge rst_48m) begin
    if (rst_48m) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; validity is tracked by level_q alone.
  always_ff @(posedge clk_48m) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= {cmd_in_type, cmd_in_data0, cmd_in_data1, cmd_in_data2, cmd_in_data3};
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_queue.sv
`default_nettype none
// ============================================================================
// tb_cmd_queue : self-checking bench for cmd_queue (vector table, directed
//                corner sequences, randomized traffic against a queue model).
// Revision     : 1.0
// ============================================================================
module tb_cmd_queue;

  logic        clk_48m = 1'b0;
  logic        rst_48m = 1'b1;
  logic        clear = 1'b0;
  logic        cmd_in_vld = 1'b0;
  logic [7:0]  cmd_in_type = '0;
  logic [15:0] cmd_in_data0 = '0, cmd_in_data1 = '0, cmd_in_data2 = '0, cmd_in_data3 = '0;
  logic        q_vld;
  logic        q_rdy = 1'b0;
  logic [7:0]  q_type;
  logic [15:0] q_data0, q_data1, q_data2, q_data3;
  logic [4:0]  q_level;
  logic        q_full, q_almost_full;
  logic [15:0] ovf_cnt;
  logic [31:0] status_word;

  cmd_queue dut (
    .clk_48m(clk_48m), .rst_48m(rst_48m), .clear(clear),
    .cmd_in_vld(cmd_in_vld), .cmd_in_type(cmd_in_type),
    .cmd_in_data0(cmd_in_data0), .cmd_in_data1(cmd_in_data1),
    .cmd_in_data2(cmd_in_data2), .cmd_in_data3(cmd_in_data3),
    .q_vld(q_vld), .q_rdy(q_rdy), .q_type(q_type),
    .q_data0(q_data0), .q_data1(q_data1), .q_data2(q_data2), .q_data3(q_data3),
    .q_level(q_level), .q_full(q_full), .q_almost_full(q_almost_full),
    .ovf_cnt(ovf_cnt), .status_word(status_word)
  );

  always #10 clk_48m = ~clk_48m;

  int total = 0;
  int bad   = 0;

  logic [71:0] mq[$];
  int          movf = 0;

  typedef struct {
    logic        vld, rdy, clr;
    logic [15:0] d0;
    logic [4:0]  exp_lvl;
    logic        exp_vld;
    logic [15:0] exp_d0;
  } vec_t;
  vec_t vt[10];

  function automatic logic [71:0] mk(input logic [7:0] t, input logic [15:0] d0);
    return {t, d0, ~d0, d0 ^ 16'hA5A5, 16'h0040};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    logic af, full;
    logic [15:0] ov;
    n    = mq.size();
    af   = (n >= 14);
    full = (n == 16);
    ov   = 16'(movf);
    chk("q_vld", q_vld, n != 0);
    chk("q_level", q_level, 72'(n));
    chk("q_full", q_full, full);
    chk("q_almost_full", q_almost_full, af);
    chk("ovf_cnt", ovf_cnt, ov);
    chk("status_word", status_word, {ov, 9'd0, af, full, 5'(n)});
    if (n > 0)
      chk("head", {q_type, q_data0, q_data1, q_data2, q_data3}, mq[0]);
  endtask

  // One clock: drive inputs, advance the reference model, then check after the edge.
  task automatic cycle(input logic vld, input logic rdy, input logic clr, input logic [71:0] cmd);
    bit pop, pok;
    cmd_in_vld = vld;
    q_rdy      = rdy;
    clear      = clr;
    {cmd_in_type, cmd_in_data0, cmd_in_data1, cmd_in_data2, cmd_in_data3} = cmd;
    if (clr) begin
      mq.delete();
      movf = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      pok = vld && (mq.size() < 16 || pop);
      if (pop) void'(mq.pop_front());
      if (pok) mq.push_back(cmd);
      else if (vld && movf < 65535) movf++;
    end
    @(posedge clk_48m);
    #1;
    cmd_in_vld = 1'b0;
    clear      = 1'b0;
    q_rdy      = 1'b0;
    check_model();
  endtask

  initial begin
    logic [95:0] rnd;
    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 5'd1, 1'b1, 16'h0010};
    vt[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b1, 16'h0010};
    vt[2] = '{1'b1, 1'b0, 1'b0, 16'h0011, 5'd2, 1'b1, 16'h0010};
    vt[3] = '{1'b1, 1'b1, 1'b0, 16'h0012, 5'd2, 1'b1, 16'h0011};
    vt[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd1, 1'b1, 16'h0012};
    vt[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 16'h0000};
    vt[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 16'h0000};
    vt[7] = '{1'b1, 1'b0, 1'b1, 16'h0099, 5'd0, 1'b0, 16'h0000};
    vt[8] = '{1'b1, 1'b0, 1'b0, 16'h0013, 5'd1, 1'b1, 16'h0013};
    vt[9] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b0, 16'h0000};

    // Reset state
    repeat (2) @(posedge clk_48m);
    #1;
    chk("rst_q_vld", q_vld, 1'b0);
    chk("rst_level", q_level, 5'd0);
    chk("rst_status", status_word, 32'd0);
    rst_48m = 1'b0;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].vld, vt[i].rdy, vt[i].clr, mk(8'h05, vt[i].d0));
      chk("tv_level", q_level, vt[i].exp_lvl);
      chk("tv_vld", q_vld, vt[i].exp_vld);
      if (vt[i].exp_vld) chk("tv_head_d0", q_data0, vt[i].exp_d0);
    end

    // Single push, then head held stable with q_rdy low
    cycle(1'b1, 1'b0, 1'b0, {8'h01, 16'h0010, 16'h0020, 16'h0030, 16'h0040});
    for (int i = 0; i < 5; i++) begin
      chk("t1_head", {q_type, q_data0, q_data1, q_data2, q_data3},
          {8'h01, 16'h0010, 16'h0020, 16'h0030, 16'h0040});
      chk("t1_level", q_level, 5'd1);
      cycle(1'b0, 1'b0, 1'b0, '0);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Fill to 16, watching the almost-full threshold
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, mk(8'h02, 16'(i)));
      if (i == 12) chk("t2_af_at13", q_almost_full, 1'b0);
      if (i == 13) chk("t2_af_at14", q_almost_full, 1'b1);
    end
    chk("t2_full", q_full, 1'b1);
    chk("t2_level", q_level, 5'd16);

    // Overflow drops
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, mk(8'h03, 16'hBEEF));
    chk("t3_ovf", ovf_cnt, 16'd3);
    chk("t3_status_hi", status_word[31:16], 16'h0003);
    chk("t3_head", q_data0, 16'd0);

    // Simultaneous push and pop while full
    cycle(1'b1, 1'b1, 1'b0, mk(8'h04, 16'h0100));
    chk("t4_level", q_level, 5'd16);
    chk("t4_ovf", ovf_cnt, 16'd3);
    chk("t4_head", q_data0, 16'd1);
    for (int k = 0; k < 16; k++) begin
      chk("t4_drain_d0", q_data0, (k < 15) ? 16'(k + 1) : 16'h0100);
      cycle(1'b0, 1'b1, 1'b0, '0);
    end
    chk("t4_empty", q_vld, 1'b0);

    // Clear wins over a same-cycle push
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 1'b0, mk(8'h06, 16'(i)));
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    chk("t5_pre_level", q_level, 5'd5);
    chk("t5_pre_ovf", ovf_cnt, 16'd2);
    cycle(1'b1, 1'b1, 1'b1, mk(8'h07, 16'h7777));
    chk("t5_level", q_level, 5'd0);
    chk("t5_vld", q_vld, 1'b0);
    chk("t5_ovf", ovf_cnt, 16'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("t5_discarded", q_level, 5'd0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, mk(8'h08, 16'(i)));
    chk("t6_pre_level", q_level, 5'd7);
    #4;
    rst_48m = 1'b1;
    #1;
    chk("t6_rst_vld", q_vld, 1'b0);
    chk("t6_rst_level", q_level, 5'd0);
    chk("t6_rst_status", status_word, 32'd0);
    mq.delete();
    movf = 0;
    @(posedge clk_48m);
    #1;
    rst_48m = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, {8'h09, 16'h1111, 16'h2222, 16'h3333, 16'h4444});
    chk("t6_level", q_level, 5'd1);
    chk("t6_head", {q_type, q_data0, q_data1, q_data2, q_data3},
        {8'h09, 16'h1111, 16'h2222, 16'h3333, 16'h4444});

    // Randomized traffic: fill-biased phase, then drain-biased phase
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      cycle($urandom_range(0, 9) < 6,
            $urandom_range(0, 9) < ((i < 1500) ? 3 : 7),
            $urandom_range(0, 199) == 0,
            rnd[71:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
